// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_unit_pkg;

    localparam int unsigned DIV_ITERS = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } muldiv_op_t;

    typedef struct packed {
        logic        wen_h;
        logic [31:0] wd_h;
        logic        wen_l;
        logic [31:0] wd_l;
    } hilo_w_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } md_state_t;

endpackage

// File: rtl/muldiv_unit_div.sv
// Unsigned 32-bit restoring divider, one quotient bit per cycle.
module div_core
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] q,
    output logic [31:0] r,
    output logic        valid
);

    logic [5:0]  cnt;
    logic        active;
    logic [31:0] dvs;

    // One restoring step: shift the next dividend bit into the partial remainder
    // and subtract the divisor if it fits.
    function automatic logic [63:0] div_step(input logic [31:0] rem,
                                             input logic [31:0] quo,
                                             input logic [31:0] dv);
        logic [32:0] part;
        logic [32:0] diff;
        part = {rem, quo[31]};
        diff = part - {1'b0, dv};
        if (!diff[32])
            return {diff[31:0], quo[30:0], 1'b1};
        else
            return {part[31:0], quo[30:0], 1'b0};
    endfunction

    // Load performs the first step from a zero remainder, so the remaining
    // DIV_ITERS-1 steps finish with valid rising after DIV_ITERS cycles in total.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            active <= 1'b0;
            dvs    <= '0;
            q      <= '0;
            r      <= '0;
        end else if (clear) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            {r, q} <= div_step('0, dividend, divisor);
            dvs    <= divisor;
            cnt    <= 6'(DIV_ITERS - 1);
            active <= 1'b1;
        end else if (active && cnt != '0) begin
            {r, q} <= div_step(r, q, dvs);
            cnt    <= cnt - 1'b1;
        end
    end

    // Result is final once all steps have run.
    always_comb begin
        valid = active && (cnt == '0);
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit writing the HI/LO register file.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        start,
    input  muldiv_op_t  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output hilo_w_t     hlw
);

    md_state_t          state, state_d;
    logic               accept;
    muldiv_op_t         op_q;
    logic [31:0]        a_q, b_q;
    logic [2:0]         mul_cnt;
    logic [63:0]        prod [MUL_STAGES];
    logic [31:0]        div_hi, div_lo;

    logic               op_is_signed;
    logic signed [32:0] mul_x, mul_y;
    logic signed [65:0] mul_full;
    logic               unused_mul_msbs;
    logic [31:0]        a_mag, b_mag;
    logic               div_load;
    logic [31:0]        core_q, core_r;
    logic               core_valid;
    logic [31:0]        q_fix, r_fix;

    // Operand preparation from the presented op: sign-extended multiply and divide magnitudes.
    always_comb begin
        op_is_signed = (op == MD_MULT) || (op == MD_DIV);
        mul_x        = {op_is_signed & a[31], a};
        mul_y        = {op_is_signed & b[31], b};
        mul_full     = mul_x * mul_y;
        a_mag        = (op_is_signed && a[31]) ? (32'd0 - a) : a;
        b_mag        = (op_is_signed && b[31]) ? (32'd0 - b) : b;
        div_load     = accept && ((op == MD_DIV) || (op == MD_DIVU));
    end

    assign unused_mul_msbs = ^mul_full[65:64];

    // Truncating-division sign fix applied to the unsigned core result.
    always_comb begin
        q_fix = core_q;
        r_fix = core_r;
        if (op_q == MD_DIV && (a_q[31] ^ b_q[31]))
            q_fix = 32'd0 - core_q;
        if (op_q == MD_DIV && a_q[31])
            r_fix = 32'd0 - core_r;
    end

    div_core u_div (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .load     (div_load),
        .dividend (a_mag),
        .divisor  (b_mag),
        .q        (core_q),
        .r        (core_r),
        .valid    (core_valid)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    // Next-state logic; flush beats everything, including a same-cycle start.
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            accept  = 1'b1;
                            state_d = (MUL_STAGES == 1) ? ST_DONE : ST_MUL;
                        end
                        MD_DIV, MD_DIVU: begin
                            accept  = 1'b1;
                            state_d = ST_DIV;
                        end
                        MD_MTHI, MD_MTLO: begin
                            accept  = 1'b1;
                            state_d = ST_DONE;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_MUL:  if (mul_cnt == 3'd1) state_d = ST_DONE;
            ST_DIV:  if (core_valid) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush)
            state_d = ST_IDLE;
    end

    // Datapath: operand capture, product pipeline, multiply countdown, divide result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= MD_MULT;
            a_q     <= '0;
            b_q     <= '0;
            mul_cnt <= '0;
            div_hi  <= '0;
            div_lo  <= '0;
            for (int unsigned i = 0; i < MUL_STAGES; i++)
                prod[i] <= '0;
        end else begin
            if (accept) begin
                op_q    <= op;
                a_q     <= a;
                b_q     <= b;
                mul_cnt <= 3'(MUL_STAGES - 1);
                prod[0] <= mul_full[63:0];
            end else if (state == ST_MUL) begin
                mul_cnt <= mul_cnt - 1'b1;
            end
            for (int unsigned i = 1; i < MUL_STAGES; i++)
                prod[i] <= prod[i-1];
            if (state == ST_FIX) begin
                if (b_q == '0) begin
                    div_hi <= a_q;
                    div_lo <= '1;
                end else begin
                    div_hi <= r_fix;
                    div_lo <= q_fix;
                end
            end
        end
    end

    // Outputs: write enables only in DONE, data from registered results.
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
        hlw  = '0;
        if (state == ST_DONE) begin
            case (op_q)
                MD_MTHI: begin
                    hlw.wen_h = 1'b1;
                    hlw.wd_h  = a_q;
                end
                MD_MTLO: begin
                    hlw.wen_l = 1'b1;
                    hlw.wd_l  = a_q;
                end
                MD_MULT, MD_MULTU: begin
                    hlw.wen_h = 1'b1;
                    hlw.wd_h  = prod[MUL_STAGES-1][63:32];
                    hlw.wen_l = 1'b1;
                    hlw.wd_l  = prod[MUL_STAGES-1][31:0];
                end
                default: begin
                    hlw.wen_h = 1'b1;
                    hlw.wd_h  = div_hi;
                    hlw.wen_l = 1'b1;
                    hlw.wd_l  = div_lo;
                end
            endcase
        end
    end

endmodule
